// File: rtl/nios2_mul_seq_if.sv
// nios2_mul_seq_if: operand-in / result-out handshake bundle for the multiply sequencer.
interface nios2_mul_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;
    modport master (
        output in_valid, src1, src2, op, out_ready,
        input  in_ready, out_valid, result, busy
    );
    modport slave (
        input  in_valid, src1, src2, op, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/nios2_mul_seq.sv
// nios2_mul_seq: 32x32 -> 64 multiply built from four 16x16 partials on one registered multiplier,
// returning the low word (MUL) or the high word (MULXUU/MULXSU/MULXSS).
module nios2_mul_seq #(
    parameter bit MUL_FAST = 1'b1
) (
    input logic            clk,
    input logic            reset_n,
    nios2_mul_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FIX, DONE} state_t;
    state_t      state;
    logic [31:0] a, b, prod, abs1, abs2;
    logic [1:0]  op_q, k, pk, last_k;
    logic        neg, neg_in;
    logic [15:0] ma, mb;
    logic [5:0]  sh;
    logic [63:0] acc, psum, r;
    always_comb begin
        abs1   = bus.src1[31] ? -bus.src1 : bus.src1;
        abs2   = bus.src2[31] ? -bus.src2 : bus.src2;
        neg_in = (bus.op == 2'b10 && bus.src1[31]) ^ (bus.op == 2'b11 && (bus.src1[31] ^ bus.src2[31]));
        ma     = k[0] ? a[31:16] : a[15:0];
        mb     = k[1] ? b[31:16] : b[15:0];
        last_k = (op_q == 2'b00 && MUL_FAST) ? 2'd2 : 2'd3;
        // pk tags which pair sits in prod, so its weight is known when it is accumulated
        sh     = pk == 2'd0 ? 6'd0 : pk == 2'd3 ? 6'd32 : 6'd16;
        psum   = acc + ({32'd0, prod} << sh);
        r      = neg ? ~acc + 64'd1 : acc;
    end
    assign bus.in_ready = state == IDLE;
    assign bus.busy     = state != IDLE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            a             <= '0;
            b             <= '0;
            op_q          <= '0;
            neg           <= 1'b0;
            k             <= '0;
            pk            <= '0;
            prod          <= '0;
            acc           <= '0;
            bus.result    <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a     <= bus.op[1] ? abs1 : bus.src1;
                    b     <= bus.op == 2'b11 ? abs2 : bus.src2;
                    neg   <= neg_in;
                    op_q  <= bus.op;
                    k     <= '0;
                    pk    <= '0;
                    prod  <= '0;
                    acc   <= '0;
                    state <= ISSUE;
                end
                ISSUE: begin
                    prod  <= {16'd0, ma} * {16'd0, mb};
                    pk    <= k;
                    acc   <= psum;
                    k     <= k + 2'd1;
                    state <= k == last_k ? DRAIN : ISSUE;
                end
                DRAIN: begin
                    acc   <= psum;
                    state <= FIX;
                end
                FIX: begin
                    bus.result    <= op_q == 2'b00 ? r[31:0] : r[63:32];
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/nios2_mul_seq.md
Name: nios2_mul_seq

Overview:
Multi-cycle multiply sequencer for the Nios II custom/ALU path. It produces the full 64-bit product of two 32-bit operands from one 16x16 unsigned multiplier with a one-clock registered product, and returns the low word (MUL) or the high word (MULXUU/MULXSU/MULXSS). It sits directly downstream of the operand fetch and upstream of writeback. It serves the instructions the single-cycle low-word mult cell cannot, using a valid/ready handshake on both sides.

Parameters:
MUL_FAST, 1, when 1 the MUL opcode skips the aH*bH partial product (5-cycle latency); when 0 all ops use 4 partials (6-cycle latency).

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  sequencer idle, can accept
src1  in  32  operand A
src2  in  32  operand B
op  in  2  00=MUL (low 32), 01=MULXUU, 10=MULXSU (A signed, B unsigned), 11=MULXSS
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  32  selected product word
busy  out  1  high in any state except IDLE

Behaviour:
- Reset, async on reset_n=0:
  - state=IDLE; out_valid=0; result=0; busy=0; in_ready=1 (combinational, in_ready = state==IDLE).
  - Accumulator, product register and counter are cleared.
  - Reset mid-operation abandons the operation; no output is produced for it.
- States: IDLE, ISSUE, DRAIN, FIX, DONE.
- IDLE:
  - On in_valid&in_ready (edge E0), latch magnitudes and state:
    - a = |src1| if op[1] else src1; b = |src2| if op==11 else src2.
    - neg = (op==10 & src1[31]) ^ (op==11 & (src1[31]^src2[31])).
    - Latch op; go to ISSUE with k=0.
  - |0x80000000| is 0x80000000 read as unsigned.
  - MUL treats both operands as unsigned.
- ISSUE:
  - Each cycle loads the multiplier inputs with pair k: k0=aL*bL (shift 0), k1=aH*bL (16), k2=aL*bH (16), k3=aH*bH (32).
  - The product register captures a pair at the next edge. The accumulator (64-bit, unsigned) adds the previous product, shifted, at the same edge.
  - Last k is 2 when op==00 and MUL_FAST=1, else 3. After the last issue, go to DRAIN.
- DRAIN: one cycle; the final product is added into the accumulator.
- FIX:
  - r = neg ? (~acc+1) : acc, 64-bit two's complement.
  - result <= (op==00) ? r[31:0] : r[63:32]; out_valid <= 1; go to DONE.
- DONE:
  - result and out_valid are held stable while out_ready=0.
  - On out_valid&out_ready, out_valid <= 0 and state -> IDLE; in_ready rises the next cycle, so back-to-back accept has one idle bubble.
- Latency: accept edge to out_valid high is 6 clocks for MULX*, and 5 for MUL with MUL_FAST=1.
- in_valid while in_ready=0 is ignored; the upstream stage holds it.
- src1/src2/op may change after acceptance without effect.
- The accumulator never overflows: the 64-bit sum of partials equals a*b < 2^64.
- No output glitch: result changes only on the FIX edge or reset.

Test Plan:
- MULXUU src1=src2=0xFFFFFFFF, out_ready=1 -> result=0xFFFFFFFE; out_valid exactly 6 clocks after accept, high for 1 cycle.
- MUL src1=0x00010003, src2=0x00020005, MUL_FAST=1 -> result=0x000B000F after 5 clocks; repeat with MUL_FAST=0 -> same value after 6 clocks.
- MULXSS:
  - -1*-1 -> 0x00000000.
  - 0x80000000*0x80000000 -> 0x40000000.
  - 0x80000000*0x00000001 -> 0xFFFFFFFF.
- MULXSU src1=0xFFFFFFFF, src2=0xFFFFFFFF -> result=0xFFFFFFFF (product 0xFFFFFFFF_00000001).
- Backpressure: out_ready=0 for 3 cycles after out_valid -> result/out_valid held, in_ready=0, and an in_valid pulse is not accepted. Then out_ready=1 -> out_valid falls and in_ready=1 the next cycle.
- Reset: reset_n low 1 cycle while in ISSUE -> out_valid=0, result=0, in_ready=1 immediately. The next MULXUU 0x00010000*0x00010000 returns 0x00000001 with normal latency.
